// File: rtl/rom_arbiter.sv
// Two-port ROM arbiter: instruction fetch (IF) and load (LS) share one ROM.
// Round-robin grant on ties, a quiet window after reset so a read that was
// in flight when reset hit can drain, and a WAIT timeout that answers with
// zero data and an err pulse.
module rom_arbiter #(
  parameter int DELAY   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  output logic [31:0] ls_rdata,
  output logic        ls_ack,
  output logic [31:0] rom_addr,
  output logic        rom_re,
  input  logic [31:0] rom_data,
  input  logic        rom_oe,
  output logic        err
);

  // One counter serves both the QUIET window and the WAIT timeout.
  localparam int CW = $clog2(TIMEOUT + DELAY + 2);
  localparam logic [CW-1:0] QUIET_LAST = CW'(DELAY);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    QUIET,
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Port currently granted; doubles as the round-robin last-grant pointer
  // (0 = IF, 1 = LS).
  logic        gnt_ls_q, gnt_ls_d;
  logic [31:0] rom_addr_q, rom_addr_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        err_q, err_d;

  // State and datapath registers; reset parks the FSM in QUIET with IF as
  // last grant so LS wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= QUIET;
      cnt_q      <= '0;
      gnt_ls_q   <= 1'b0;
      rom_addr_q <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_ls_q   <= gnt_ls_d;
      rom_addr_q <= rom_addr_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: requests are only sampled in IDLE, rom_oe only in WAIT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_ls_d   = gnt_ls_q;
    rom_addr_d = rom_addr_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    err_d      = err_q;
    case (state_q)
      QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE: begin
        err_d = 1'b0;
        if (if_req && ls_req) begin
          gnt_ls_d   = ~gnt_ls_q;
          rom_addr_d = gnt_ls_q ? if_addr : ls_addr;
          state_d    = ISSUE;
        end else if (if_req) begin
          gnt_ls_d   = 1'b0;
          rom_addr_d = if_addr;
          state_d    = ISSUE;
        end else if (ls_req) begin
          gnt_ls_d   = 1'b1;
          rom_addr_d = ls_addr;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rom_oe) begin
          if (gnt_ls_q) ls_rdata_d = rom_data;
          else          if_rdata_d = rom_data;
          state_d = RESP;
        end else if (cnt_q == WAIT_LAST) begin
          if (gnt_ls_q) ls_rdata_d = '0;
          else          if_rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = QUIET;
        cnt_d   = '0;
      end
    endcase
  end

  assign rom_re   = (state_q == ISSUE);
  assign rom_addr = rom_addr_q;
  assign if_ack   = (state_q == RESP) && !gnt_ls_q;
  assign ls_ack   = (state_q == RESP) &&  gnt_ls_q;
  assign err      = (state_q == RESP) &&  err_q;
  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter: a behavioural ROM with a fixed read delay, a
// scoreboard of expected responses, and directed scenarios for single fetch,
// tie-break, contention, timeout, reset abort and ack release.
module tb_rom_arbiter;

  localparam int DELAY   = 5;
  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        if_req, ls_req;
  logic [31:0] if_addr, ls_addr;
  logic [31:0] if_rdata, ls_rdata;
  logic        if_ack, ls_ack;
  logic [31:0] rom_addr;
  logic        rom_re;
  logic [31:0] rom_data;
  logic        rom_oe;
  logic        err;

  typedef struct packed {
    logic        isLs;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sbQ[$];
  int          assertCount = 0;
  int          failCount   = 0;
  int          pushedTotal = 0;
  int          cyc         = 0;
  int          ackCount    = 0;
  int          reConsec    = 0;
  int          errAlone    = 0;
  int          lastAckCyc  = 0;
  int          reCyc       = 0;
  logic        prevRe      = 1'b0;
  logic        romOeEn;
  logic [31:0] lastIf, lastLs;
  logic [DELAY:0] pipe = '0;
  logic [31:0] dataHold = '0;

  rom_arbiter #(.DELAY(DELAY), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_rdata(if_rdata),
    .if_ack  (if_ack),
    .ls_req  (ls_req),
    .ls_addr (ls_addr),
    .ls_rdata(ls_rdata),
    .ls_ack  (ls_ack),
    .rom_addr(rom_addr),
    .rom_re  (rom_re),
    .rom_data(rom_data),
    .rom_oe  (rom_oe),
    .err     (err)
  );

  // Free-running 100 MHz-style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word 4 holds the well-known pattern, everything else is
  // derived from the word-aligned address so each location is distinct.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    if (a[31:2] == 30'd4) return 32'hDEADBEEF;
    return {a[31:2], 2'b00} ^ 32'h5A5A_1234;
  endfunction

  // Behavioural ROM: a read strobe produces oe DELAY+1 cycles later; it is
  // deliberately not reset so an interrupted read still pulses oe.
  always @(posedge clk) begin
    pipe <= {pipe[DELAY-1:0], rom_re};
    if (rom_re) dataHold <= romWord(rom_addr);
  end
  assign rom_oe   = pipe[DELAY] & romOeEn;
  assign rom_data = dataHold;

  // Cycle counter used to time acks against read strobes.
  always @(posedge clk) cyc <= cyc + 1;

  // Background watch: back-to-back strobes, total ack count, stray err.
  always @(negedge clk) begin
    if (rom_re && prevRe) reConsec <= reConsec + 1;
    prevRe <= rom_re;
    if (if_ack) ackCount <= ackCount + 1;
    if (ls_ack) ackCount <= ackCount + 1;
    if (err && !(if_ack || ls_ack)) errAlone <= errAlone + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input logic isLs, input logic [31:0] addr);
    exp_t e;
    e.isLs = isLs;
    e.data = romOeEn ? romWord(addr) : 32'h0;
    e.err  = !romOeEn;
    sbQ.push_back(e);
    pushedTotal++;
  endtask

  task automatic applyStimulus(input logic isLs, input logic [31:0] addr);
    if (isLs) begin
      ls_addr = addr;
      ls_req  = 1'b1;
    end else begin
      if_addr = addr;
      if_req  = 1'b1;
    end
    pushExp(isLs, addr);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1 rst = 1'b1;
    lastIf = '0;
    lastLs = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic waitRe(input string tag, input logic [31:0] expAddr, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      seen = rom_re;
    end
    checkOutput({tag, "_re_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_rom_addr"}, rom_addr, expAddr);
    reCyc = cyc;
  endtask

  task automatic collectAck(input string tag);
    int   n;
    logic seen;
    exp_t e;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      seen = if_ack | ls_ack;
    end
    checkOutput({tag, "_ack_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      lastAckCyc = cyc;
      checkOutput({tag, "_sb_nonempty"}, 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        checkOutput({tag, "_ls_ack"}, 32'(ls_ack), 32'(e.isLs));
        checkOutput({tag, "_if_ack"}, 32'(if_ack), 32'(!e.isLs));
        checkOutput({tag, "_err"}, 32'(err), 32'(e.err));
        if (e.isLs) begin
          checkOutput({tag, "_ls_rdata"}, ls_rdata, e.data);
          checkOutput({tag, "_if_rdata_hold"}, if_rdata, lastIf);
          lastLs = e.data;
        end else begin
          checkOutput({tag, "_if_rdata"}, if_rdata, e.data);
          checkOutput({tag, "_ls_rdata_hold"}, ls_rdata, lastLs);
          lastIf = e.data;
        end
      end
    end
  endtask

  // Directed scenario sequence.
  initial begin
    int n, a1, a2;
    rst     = 1'b1;
    if_req  = 1'b0;
    ls_req  = 1'b0;
    if_addr = '0;
    ls_addr = '0;
    romOeEn = 1'b1;
    lastIf  = '0;
    lastLs  = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_rom_re", 32'(rom_re), 32'd0);
    checkOutput("rst_rom_addr", rom_addr, 32'd0);
    checkOutput("rst_if_ack", 32'(if_ack), 32'd0);
    checkOutput("rst_ls_ack", 32'(ls_ack), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_if_rdata", if_rdata, 32'd0);
    checkOutput("rst_ls_rdata", ls_rdata, 32'd0);

    // Single fetch straight out of reset.
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 32'h10);
    waitRe("t1", 32'h10, n);
    checkOutput("t1_grant_latency", 32'(n), 32'(DELAY + 3));
    @(negedge clk);
    checkOutput("t1_re_pulse", 32'(rom_re), 32'd0);
    collectAck("t1");
    checkOutput("t1_ack_latency", 32'(lastAckCyc - reCyc), 32'(DELAY + 2));
    if_req = 1'b0;

    // Load with unaligned address so last grant becomes LS before reset.
    applyStimulus(1'b1, 32'h23);
    waitRe("t1b", 32'h23, n);
    collectAck("t1b");
    ls_req = 1'b0;

    // Tie right after reset: LS first, acks one transaction period apart.
    applyReset();
    applyStimulus(1'b1, 32'h30);
    applyStimulus(1'b0, 32'h44);
    waitRe("t2_ls", 32'h30, n);
    checkOutput("t2_quiet_latency", 32'(n), 32'(DELAY + 3));
    collectAck("t2_ls");
    a1 = lastAckCyc;
    ls_req = 1'b0;
    waitRe("t2_if", 32'h44, n);
    collectAck("t2_if");
    a2 = lastAckCyc;
    if_req = 1'b0;
    checkOutput("t2_ack_spacing", 32'(a2 - a1), 32'(DELAY + 4));

    // Sustained contention: both held for four transactions.
    applyStimulus(1'b1, 32'h50);
    applyStimulus(1'b0, 32'h64);
    pushExp(1'b1, 32'h50);
    pushExp(1'b0, 32'h64);
    for (int k = 0; k < 4; k++) begin
      waitRe("t3", (k % 2 == 1) ? 32'h64 : 32'h50, n);
      collectAck("t3");
    end
    if_req = 1'b0;
    ls_req = 1'b0;

    // Timeout: ROM never answers.
    romOeEn = 1'b0;
    applyStimulus(1'b0, 32'h70);
    waitRe("t4", 32'h70, n);
    collectAck("t4");
    checkOutput("t4_timeout_latency", 32'(lastAckCyc - reCyc), 32'(TIMEOUT + 1));
    if_req  = 1'b0;
    romOeEn = 1'b1;

    // Reset three cycles after the strobe aborts the read.
    if_addr = 32'h88;
    if_req  = 1'b1;
    waitRe("t5", 32'h88, n);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    if_req = 1'b0;
    lastIf = '0;
    lastLs = '0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("t5_rst_ack", 32'(if_ack), 32'd0);
      checkOutput("t5_rst_ls_rdata", ls_rdata, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 32'h10);
    for (int k = 0; k < DELAY + 1; k++) begin
      @(negedge clk);
      checkOutput("t5_quiet_re", 32'(rom_re), 32'd0);
      checkOutput("t5_quiet_ack", 32'(if_ack), 32'd0);
    end
    waitRe("t5_new", 32'h10, n);
    collectAck("t5_new");

    // Requester drops on ack and immediately asks for a new address.
    if_req = 1'b0;
    @(posedge clk);
    #1 applyStimulus(1'b0, 32'h204);
    waitRe("t6", 32'h204, n);
    collectAck("t6");
    if_req = 1'b0;

    repeat (12) @(negedge clk);
    checkOutput("final_ack_count", 32'(ackCount), 32'(pushedTotal));
    checkOutput("final_sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("final_re_consecutive", 32'(reConsec), 32'd0);
    checkOutput("final_err_without_ack", 32'(errAlone), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter DELAY, default 5, the ROM access delay in cycles; SHALL equal the DELAY of the attached rom instance.
REQ-002 Parameter TIMEOUT, default 15, the maximum cycles spent in WAIT before an error response; SHALL be greater than DELAY+1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request, held high until if_ack.
REQ-006 if_addr  input  32  fetch byte address, stable while if_req is high.
REQ-007 if_rdata  output  32  fetch read data, valid while if_ack is high.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 ls_req / ls_addr / ls_rdata / ls_ack  1/32/32/1  load port, same semantics as the if_* ports.
REQ-010 rom_addr  output  32  address to the ROM, registered.
REQ-011 rom_re  output  1  ROM read strobe.
REQ-012 rom_data  input  32  ROM read data.
REQ-013 rom_oe  input  1  ROM data-valid pulse.
REQ-014 err  output  1  one-cycle pulse, coincident with the ack of a timed-out access.

Function
REQ-015 FSM states SHALL be QUIET, IDLE, ISSUE, WAIT and RESP.
REQ-016 QUIET: count DELAY+1 cycles, then go to IDLE; requests are not granted in QUIET.
REQ-017 IDLE, no request pending: stay in IDLE.
REQ-018 IDLE, one request pending: grant it, latch its address into rom_addr, go to ISSUE.
REQ-019 IDLE, both requests pending: grant the port not granted last (round-robin); the last-grant pointer resets to IF, so LS wins the first tie.
REQ-020 ISSUE SHALL last exactly one cycle, with rom_re=1, then go to WAIT.
REQ-021 rom_re SHALL be 0 in every state other than ISSUE.
REQ-022 WAIT, rom_oe=1: capture rom_data into the granted port's rdata register and go to RESP.
REQ-023 WAIT timeout: if TIMEOUT cycles elapse in WAIT without rom_oe, load rdata with 0x00000000, set err, and go to RESP.
REQ-024 RESP SHALL last one cycle: the granted port's ack=1 (plus err if timed out), then go to IDLE.
REQ-025 Requests SHALL NOT be sampled in RESP, so a requester dropping req on ack is never re-granted.
REQ-026 Latency: req seen in IDLE at cycle 0 -> rom_re at cycle 1 -> rom_oe at cycle DELAY+2 -> ack at cycle DELAY+3 (cycle 8 for DELAY=5).
REQ-027 Throughput: the next grant is possible at cycle DELAY+4.
REQ-028 rom_oe outside WAIT SHALL be ignored.
REQ-029 The ungranted port's ack, rdata and req SHALL be unaffected by the other port's transaction.
REQ-030 rdata registers SHALL hold their last value between acks.
REQ-031 rom_addr SHALL be stable from ISSUE through RESP.
REQ-032 Addresses SHALL pass unmodified; the low two bits are ignored downstream.
REQ-033 A req deasserted before grant SHALL be treated as withdrawn; a req deasserted after grant SHALL still complete with ack.

Reset
REQ-034 While rst=1: state=QUIET, quiet counter=0, last-grant=IF.
REQ-035 While rst=1: rom_re=0, rom_addr=0, if_ack=ls_ack=0, err=0, if_rdata=ls_rdata=0.
REQ-036 Reset mid-transaction SHALL abort it with no ack.
REQ-037 After reset, the QUIET window SHALL let any in-flight ROM count drain before the next ISSUE.

Verification
REQ-038 Single fetch: rst released, QUIET done, if_req=1, if_addr=0x10, ROM word 4=0xDEADBEEF -> rom_re pulse 1 cycle with rom_addr=0x10; if_ack 1 cycle at cycle 8 after grant, if_rdata=0xDEADBEEF; ls_ack stays 0.
REQ-039 Tie: if_req and ls_req rise in the same cycle after reset -> LS served first, then IF; two acks exactly 9 cycles apart; rom_re never high for 2 consecutive cycles.
REQ-040 Sustained contention: both requests held for 4 transactions -> grants alternate LS, IF, LS, IF.
REQ-041 Timeout: ROM model never asserts oe -> ack with rdata=0 and err=1 TIMEOUT+1 cycles after ISSUE; FSM returns to IDLE.
REQ-042 Reset mid-WAIT: rst pulsed 3 cycles after rom_re -> no ack; rom_re stays 0 for DELAY+1 cycles after release; next request returns correct data.
REQ-043 Ack release: requester drops req on ack, then immediately raises a new req to a different address -> exactly one ack per request, and the new rom_addr is correct.
